data_serialize: RTL

Reads a bank of 64 stored 11-bit slot values and streams them out one slot per transfer over a valid/ready handshake. The stream carries the slot index and frame markers. It is the read-side counterpart of the indexed slot store, which writes `data` into slot `dataChange`. It sits between that store's 64 `signal*` outputs, flattened into one bus, and any downstream consumer that needs the slots sequentially, such as a display scanner or a UART framer. A frame is a snapshot of all 64 slots taken at one clock edge, so writes to the store mid-frame never tear a frame.

---
 rtl/data_serialize_pkg.sv | 13 +
 rtl/data_serialize_slot_snapshot.sv | 47 ++++
 rtl/data_serialize.sv | 115 +++++++++++
 3 files changed

// File: rtl/data_serialize_pkg.sv
// Shared constants and state encoding for the slot-bank serializer.
package data_serialize_pkg;

  localparam int SLOT_N = 64;
  localparam int SLOT_W = 11;
  localparam int IDX_W  = 6;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

endpackage : data_serialize_pkg

// File: rtl/data_serialize_slot_snapshot.sv
// Snapshot bank: captures the whole flattened slot bus in one edge so a frame
// never mixes old and new slot values, and offers a combinational read port.
module slot_snapshot #(
  parameter int SLOT_N = data_serialize_pkg::SLOT_N,
  parameter int SLOT_W = data_serialize_pkg::SLOT_W,
  parameter int IDX_W  = data_serialize_pkg::IDX_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load,
  input  logic [SLOT_N*SLOT_W-1:0] slots_in,
  input  logic [IDX_W-1:0]         rd_index,
  output logic [SLOT_W-1:0]        rd_data
);

  logic [SLOT_W-1:0] snap_q [SLOT_N];
  logic [SLOT_W-1:0] snap_d [SLOT_N];

  // Next snapshot: hold, or take the entire bus when loading.
  always_comb begin
    for (int i = 0; i < SLOT_N; i++) begin
      snap_d[i] = snap_q[i];
      if (load) begin
        snap_d[i] = slots_in[i*SLOT_W +: SLOT_W];
      end
    end
  end

  // Snapshot registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SLOT_N; i++) begin
        snap_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < SLOT_N; i++) begin
        snap_q[i] <= snap_d[i];
      end
    end
  end

  // Read mux selecting the slot currently being streamed.
  always_comb begin
    rd_data = snap_q[rd_index];
  end

endmodule : slot_snapshot

// File: rtl/data_serialize.sv
// Streams a snapshot of the slot bank out one slot per valid/ready beat,
// with index, first/last markers, and a frame-complete pulse.
//
// state | meaning
// IDLE  | no frame in progress; start or continuous takes a snapshot
// SEND  | presenting snapshot[index]; advances on each accepted beat
module data_serialize #(
  parameter int SLOT_N = data_serialize_pkg::SLOT_N,
  parameter int SLOT_W = data_serialize_pkg::SLOT_W,
  parameter int IDX_W  = data_serialize_pkg::IDX_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     continuous,
  input  logic [SLOT_N*SLOT_W-1:0] slots_in,
  output logic [SLOT_W-1:0]        out_data,
  output logic [IDX_W-1:0]         out_index,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_first,
  output logic                     out_last,
  output logic                     busy,
  output logic                     frame_done
);

  import data_serialize_pkg::*;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SLOT_N - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              frame_done_q, frame_done_d;
  logic              load;
  logic              xfer;
  logic [SLOT_W-1:0] rd_data;

  slot_snapshot #(
    .SLOT_N (SLOT_N),
    .SLOT_W (SLOT_W),
    .IDX_W  (IDX_W)
  ) u_snapshot (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .slots_in (slots_in),
    .rd_index (idx_q),
    .rd_data  (rd_data)
  );

  // Next state, index counter, snapshot load and end-of-frame pulse.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    frame_done_d = 1'b0;
    load         = 1'b0;
    xfer         = (state_q == SEND) && out_ready;
    unique case (state_q)
      IDLE: begin
        // start is only looked at here, so a start during SEND is dropped.
        if (start || continuous) begin
          load    = 1'b1;
          idx_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (xfer) begin
          if (idx_q == LAST_IDX) begin
            frame_done_d = 1'b1;
            idx_d        = '0;
            if (continuous) begin
              // Re-snapshot on the final beat so index 0 follows without a gap.
              load    = 1'b1;
              state_d = SEND;
            end else begin
              state_d = IDLE;
            end
          end else begin
            idx_d = idx_q + IDX_ONE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, index and pulse registers; reset wins over any transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Stream outputs are forced low outside SEND so IDLE shows a quiet bus.
  always_comb begin
    out_valid  = (state_q == SEND);
    busy       = (state_q == SEND);
    out_data   = out_valid ? rd_data : '0;
    out_index  = out_valid ? idx_q : '0;
    out_first  = out_valid && (idx_q == '0);
    out_last   = out_valid && (idx_q == LAST_IDX);
    frame_done = frame_done_q;
  end

endmodule : data_serialize
